// File: rtl/indication_word_serializer.sv
// Buffers 96-bit {v, meth, tag} indication messages in a small FIFO and emits
// each as three 32-bit words (tag, meth, v) with a last flag on the final word.
module indication_word_serializer #(
  parameter int DEPTH = 2,
  parameter int CNTW  = 16
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            pipe_enq_ena,
  input  logic [95:0]     pipe_enq_v,
  output logic            pipe_enq_rdy,
  output logic            word_enq_ena,
  output logic [31:0]     word_enq_data,
  output logic            word_enq_last,
  input  logic            word_enq_rdy,
  output logic [CNTW-1:0] msg_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    B0 = 2'd0,
    B1 = 2'd1,
    B2 = 2'd2
  } beat_t;

  beat_t            beat_reg, beat_next;
  logic [95:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      occ_reg;
  logic [CNTW-1:0]  msg_count_reg;
  logic             push, xfer, pop;
  logic [95:0]      head;

  // No bypass: a full FIFO refuses a push even while it pops.
  assign pipe_enq_rdy = nRST & (occ_reg != FULL);
  assign word_enq_ena = (occ_reg != '0);
  assign push         = pipe_enq_ena & pipe_enq_rdy;
  assign xfer         = word_enq_ena & word_enq_rdy;
  assign head         = mem[rd_ptr_reg];
  assign msg_count    = msg_count_reg;

  always_comb begin
    beat_next     = beat_reg;
    pop           = 1'b0;
    word_enq_data = 32'd0;
    word_enq_last = 1'b0;
    if (xfer) begin
      case (beat_reg)
        B0: beat_next = B1;
        B1: beat_next = B2;
        B2: begin
          beat_next = B0;
          pop       = 1'b1;
        end
        default: beat_next = B0;
      endcase
    end
    if (word_enq_ena) begin
      case (beat_reg)
        B0:      word_enq_data = head[31:0];
        B1:      word_enq_data = head[63:32];
        B2:      word_enq_data = head[95:64];
        default: word_enq_data = 32'd0;
      endcase
      word_enq_last = (beat_reg == B2);
    end
  end

  // Payload storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr_reg] <= pipe_enq_v;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      beat_reg      <= B0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      occ_reg       <= '0;
      msg_count_reg <= '0;
    end else begin
      beat_reg <= beat_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg    <= rd_ptr_reg + AW'(1);
        msg_count_reg <= msg_count_reg + CNTW'(1);
      end
      case ({push, pop})
        2'b10:   occ_reg <= occ_reg + (AW+1)'(1);
        2'b01:   occ_reg <= occ_reg - (AW+1)'(1);
        default: occ_reg <= occ_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_indication_word_serializer.sv
// Directed and randomized checks of indication_word_serializer against a
// message-queue reference model evaluated every cycle.
module tb_indication_word_serializer;

  localparam int DEPTH = 2;
  localparam int CNTW  = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            pipe_ena;
  logic [95:0]     pipe_v;
  logic            pipe_rdy;
  logic            word_ena;
  logic [31:0]     word_data;
  logic            word_last;
  logic            word_rdy;
  logic [CNTW-1:0] msg_count;

  int total = 0;
  int bad   = 0;

  // Reference model: queued messages, index of the next word of the head, count.
  logic [95:0] mq[$];
  int          mbeat  = 0;
  int          mcnt   = 0;
  int          pushes = 0;

  logic        obs_ena, obs_rdy, obs_last;
  logic [31:0] obs_data;
  logic [31:0] obs_cnt;

  indication_word_serializer #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .CLK           (clk),
    .nRST          (rst_n),
    .pipe_enq_ena  (pipe_ena),
    .pipe_enq_v    (pipe_v),
    .pipe_enq_rdy  (pipe_rdy),
    .word_enq_ena  (word_ena),
    .word_enq_data (word_data),
    .word_enq_last (word_last),
    .word_enq_rdy  (word_rdy),
    .msg_count     (msg_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: compare DUT outputs with the model at the falling edge,
  // advance the model with the inputs the DUT will sample, then return just
  // after the rising edge so the caller can drive the next inputs.
  task automatic cycle();
    logic [95:0] hd;
    logic        e_ena, e_rdy, e_last, x, p;
    logic [31:0] e_data;
    @(negedge clk);
    e_ena  = (mq.size() != 0);
    e_rdy  = rst_n && (mq.size() < DEPTH);
    e_data = 32'd0;
    e_last = 1'b0;
    if (e_ena) begin
      hd     = mq[0];
      e_data = hd[mbeat*32 +: 32];
      e_last = (mbeat == 2);
    end
    obs_ena  = word_ena;
    obs_rdy  = pipe_rdy;
    obs_last = word_last;
    obs_data = word_data;
    obs_cnt  = {28'd0, msg_count};
    check_val("ena",  {31'd0, obs_ena},  {31'd0, e_ena});
    check_val("rdy",  {31'd0, obs_rdy},  {31'd0, e_rdy});
    check_val("data", obs_data, e_data);
    check_val("last", {31'd0, obs_last}, {31'd0, e_last});
    check_val("cnt",  obs_cnt, 32'(mcnt % 16));
    x = e_ena && word_rdy;
    p = pipe_ena && e_rdy;
    if (x) begin
      if (mbeat == 2) begin
        mbeat = 0;
        void'(mq.pop_front());
        mcnt++;
        $display("message emitted, total emitted %0d", mcnt);
      end else begin
        mbeat++;
      end
    end
    if (p) begin
      mq.push_back(pipe_v);
      pushes++;
    end
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; drops reset asynchronously mid-cycle.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_ena",  {31'd0, word_ena},  32'd0);
    check_val("rst_last", {31'd0, word_last}, 32'd0);
    check_val("rst_rdy",  {31'd0, pipe_rdy},  32'd0);
    check_val("rst_cnt",  {28'd0, msg_count}, 32'd0);
    mq.delete();
    mbeat = 0;
    mcnt  = 0;
  endtask

  initial begin
    logic [95:0] a, b, c, d, e, f, g, h, j;
    logic [31:0] exp_w[6];

    rst_n    = 1'b1;
    pipe_ena = 1'b0;
    pipe_v   = '0;
    word_rdy = 1'b0;
    #1 rst_n = 1'b0;
    cycle();
    cycle();
    #2 rst_n = 1'b1;
    cycle();
    check_val("reset_rdy", {31'd0, obs_rdy}, 32'd1);
    check_val("reset_ena", {31'd0, obs_ena}, 32'd0);

    // Single message
    word_rdy = 1'b1;
    pipe_v   = {32'hCAFE0003, 32'h00000002, 32'h00000001};
    pipe_ena = 1'b1;
    cycle();
    pipe_ena = 1'b0;
    exp_w[0] = 32'h00000001;
    exp_w[1] = 32'h00000002;
    exp_w[2] = 32'hCAFE0003;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_val("single_word", obs_data, exp_w[i]);
      check_val("single_last", {31'd0, obs_last}, (i == 2) ? 32'd1 : 32'd0);
      check_val("single_cnt0", obs_cnt, 32'd0);
    end
    cycle();
    check_val("single_cnt1", obs_cnt, 32'd1);

    // Fill and overflow with downstream stalled
    a = {32'hA0000003, 32'hA0000002, 32'hA0000001};
    b = {32'hB0000003, 32'hB0000002, 32'hB0000001};
    c = {32'hC0000003, 32'hC0000002, 32'hC0000001};
    word_rdy = 1'b0;
    pipe_ena = 1'b1;
    pipe_v   = a;
    cycle();
    pipe_v = b;
    cycle();
    pipe_v = c;
    cycle();
    check_val("ovf_rdy", {31'd0, obs_rdy}, 32'd0);
    pipe_ena = 1'b0;
    word_rdy = 1'b1;
    exp_w = '{a[31:0], a[63:32], a[95:64], b[31:0], b[63:32], b[95:64]};
    for (int i = 0; i < 6; i++) begin
      cycle();
      check_val("ovf_word", obs_data, exp_w[i]);
      check_val("ovf_rdy_ret", {31'd0, obs_rdy}, (i >= 3) ? 32'd1 : 32'd0);
    end
    cycle();
    check_val("ovf_c_dropped", {31'd0, obs_ena}, 32'd0);

    // Stall in the middle of a message
    d = {32'hD0000003, 32'hD0000002, 32'hD0000001};
    pipe_v   = d;
    pipe_ena = 1'b1;
    cycle();
    pipe_ena = 1'b0;
    cycle();
    check_val("stall_tag", obs_data, d[31:0]);
    word_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_val("stall_meth", obs_data, d[63:32]);
      check_val("stall_last", {31'd0, obs_last}, 32'd0);
    end
    word_rdy = 1'b1;
    cycle();
    check_val("stall_meth_go", obs_data, d[63:32]);
    cycle();
    check_val("stall_v", obs_data, d[95:64]);
    check_val("stall_v_last", {31'd0, obs_last}, 32'd1);
    cycle();

    // Push in the same cycle as the head's final transfer
    e = {32'hE0000003, 32'hE0000002, 32'hE0000001};
    f = {32'hF0000003, 32'hF0000002, 32'hF0000001};
    pipe_v   = e;
    pipe_ena = 1'b1;
    cycle();
    pipe_ena = 1'b0;
    cycle();
    cycle();
    pipe_v   = f;
    pipe_ena = 1'b1;
    cycle();
    check_val("conc_e_last", {31'd0, obs_last}, 32'd1);
    pipe_ena = 1'b0;
    cycle();
    check_val("conc_f_tag", obs_data, f[31:0]);
    check_val("conc_rdy", {31'd0, obs_rdy}, 32'd1);
    cycle();
    cycle();

    // Asynchronous reset in B1 with two messages queued
    g = {32'h60000003, 32'h60000002, 32'h60000001};
    h = {32'h70000003, 32'h70000002, 32'h70000001};
    word_rdy = 1'b0;
    pipe_ena = 1'b1;
    pipe_v   = g;
    cycle();
    pipe_v = h;
    cycle();
    pipe_ena = 1'b0;
    word_rdy = 1'b1;
    cycle();
    check_val("prerst_tag", obs_data, g[31:0]);
    async_reset();
    cycle();
    cycle();
    #2 rst_n = 1'b1;
    j = {32'h90000003, 32'h90000002, 32'h90000001};
    pipe_v   = j;
    pipe_ena = 1'b1;
    cycle();
    pipe_ena = 1'b0;
    cycle();
    check_val("postrst_tag", obs_data, j[31:0]);
    cycle();
    cycle();

    // Counter wrap: 17 messages from zero
    async_reset();
    cycle();
    #2 rst_n = 1'b1;
    pushes   = 0;
    pipe_ena = 1'b1;
    word_rdy = 1'b1;
    for (int k = 0; k < 300 && pushes < 17; k++) begin
      pipe_v = {$urandom, $urandom, $urandom};
      cycle();
    end
    pipe_ena = 1'b0;
    check_val("wrap_push_timeout", 32'(pushes), 32'd17);
    for (int k = 0; k < 300 && mq.size() > 0; k++) cycle();
    check_val("wrap_drain_timeout", 32'(mq.size()), 32'd0);
    cycle();
    check_val("wrap_cnt", obs_cnt, 32'd1);

    // Randomized traffic with random backpressure
    for (int k = 0; k < 1500; k++) begin
      pipe_ena = 1'($urandom_range(0, 1));
      pipe_v   = {$urandom, $urandom, $urandom};
      word_rdy = ($urandom_range(0, 3) != 0);
      cycle();
    end
    pipe_ena = 1'b0;
    word_rdy = 1'b1;
    for (int k = 0; k < 50 && mq.size() > 0; k++) cycle();
    check_val("final_drain", 32'(mq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
